fp16_acc: RTL and testbench
===========================

Name: fp16_acc

Overview:
- Streaming FP16 accumulator that sits directly downstream of the FP16 multiplier and consumes its product stream over a valid/ready handshake.
- Sums a group of FP16 values, delimited by in_last, into one FP16 result for dot-product style reductions.
- Uses a multi-cycle add FSM, one element per 4 cycles.
- Numeric policy matches the multiplier: exponent 0 is zero (flush), truncating rounding, no inf/NaN.

Parameters:
CNT_W, 8, width of the per-group element counter (saturates at all-ones).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream element valid
in_ready  output  1  block can accept an element; combinational, = (state==IDLE)
in_data  input  16  FP16 element (sign, exp[14:10], frac[9:0])
in_last  input  1  element is the last of its group; sampled with in_data
out_valid  output  1  group sum valid; = (state==OUT)
out_ready  input  1  downstream accepts sum
out_sum  output  16  accumulated FP16 group sum (acc register)
out_count  output  CNT_W  number of elements accepted in the group

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - state=IDLE, acc=16'h0000, count=0, latched operand/last cleared.
  - Outputs: out_valid=0, out_sum=0, out_count=0, in_ready=1.
  - Reset mid-operation discards the in-flight element and partial sum.
- States: IDLE, ALIGN, ADD, NORM, OUT.
- IDLE: on in_valid&in_ready (edge t0), latch in_data and in_last, count<=count+1 (saturating), go to ALIGN.
- Operand decode (both acc and input):
  - exp==0 → value zero (frac ignored).
  - exp==31 → treated as max finite (exp 30, frac 3FF).
  - Mantissa = {1, frac} extended with 3 zero guard bits (14 bits).
- ALIGN (t0→t1):
  - Operand with the larger exponent is "big"; the other's mantissa is shifted right by the exponent difference.
  - Difference ≥14 → shifted mantissa = 0.
  - A zero operand has mantissa 0 and contributes nothing.
- ADD (t1→t2):
  - Same sign: 15-bit sum.
  - Different sign: larger magnitude minus smaller; result sign = sign of larger magnitude.
  - Exact zero result is forced to +0.
- NORM (t2→t3):
  - Carry bit set: shift right 1, exp+1.
  - Otherwise: left shift by leading-zero count, exp−lz (single-cycle priority encoder).
  - exp ≤ 0 → +0 (flush).
  - exp ≥ 31 → saturate to sign|0x7BFF.
  - Drop guard bits (round toward zero); write acc.
  - Next state: OUT if latched last, else IDLE.
- Timing: busy for 3 cycles after an accept; in_ready is high again after edge t3. Sustained throughput is 1 element / 4 cycles.
- OUT:
  - out_valid=1, out_sum=acc, out_count=count; both held stable while out_ready=0.
  - in_ready=0 throughout OUT, so no element is accepted while the sum is pending.
  - On out_ready: acc<=0, count<=0, state→IDLE. The next group starts from +0.
- out_valid is low in all states except OUT.
- Every group needs a last-flagged element; there is no empty-group output.

Test Plan:
1. Single element 0x3C00 with in_last=1 → out_sum=0x3C00, out_count=1, out_valid rises 3 cycles after accept.
2. Group 0x3C00, 0x4000, 0x3800(last) → out_sum=0x4300 (3.5), out_count=3; in_ready low exactly 3 cycles after each accept.
3. Cancellation and flush:
   - Group 0x3C00, 0xBC00(last) → out_sum=0x0000.
   - Subnormal group 0x0200, 0x3C00(last) → 0x3C00.
4. Saturation:
   - 0x7BFF, 0x7BFF(last) → 0x7BFF.
   - 0xFBFF, 0xFBFF(last) → 0xFBFF.
   - Input 0x7C00 alone → 0x7BFF.
5. Alignment truncation: 0x6400, 0x3400(last) → 0x6400 (0.25 lost below ulp). Then 0x3C00, 0x3555(last) → 0x3D55 (truncated).
6. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles in OUT with in_valid=1 → in_ready=0, out_sum stable.
   - Release → next group sums from 0.
   - Assert rst_n mid-NORM → out_valid=0, acc=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/fp16_acc.sv
// Streaming FP16 group accumulator: one element per 4 cycles through ALIGN/ADD/NORM,
// emitting the group sum when the last-flagged element has been folded in.
module fp16_acc #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_sum,
   output logic [CNT_W-1:0] out_count
);

   localparam int unsigned MW = 14;

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

   state_t           state;
   logic [15:0]      acc;
   logic [15:0]      op_r;
   logic             last_r;
   logic [CNT_W-1:0] count;

   logic             big_sign, sml_sign;
   logic [4:0]       big_exp;
   logic [MW-1:0]    big_mant, sml_mant;

   logic [MW:0]      sum_r;
   logic             sum_sign;
   logic [4:0]       sum_exp;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);
   assign out_sum   = acc;
   assign out_count = count;

   // Operand decode and alignment (acc vs latched element)
   logic          a_zero, b_zero;
   logic [4:0]    a_exp, b_exp, e_diff;
   logic [9:0]    a_frac, b_frac;
   logic [MW-1:0] a_mant, b_mant, al_big_m, al_sml_m, al_shift_m;
   logic          al_big_s, al_sml_s;
   logic [4:0]    al_big_e;

   always_comb begin
      a_zero = (acc[14:10] == 5'd0);
      b_zero = (op_r[14:10] == 5'd0);
      a_exp  = (acc[14:10] == 5'd31) ? 5'd30 : acc[14:10];
      b_exp  = (op_r[14:10] == 5'd31) ? 5'd30 : op_r[14:10];
      a_frac = (acc[14:10] == 5'd31) ? 10'h3FF : acc[9:0];
      b_frac = (op_r[14:10] == 5'd31) ? 10'h3FF : op_r[9:0];
      a_mant = a_zero ? '0 : {1'b1, a_frac, 3'b000};
      b_mant = b_zero ? '0 : {1'b1, b_frac, 3'b000};
      if (a_exp >= b_exp) begin
         al_big_s = acc[15];  al_big_e = a_exp; al_big_m = a_mant;
         al_sml_s = op_r[15]; al_sml_m = b_mant;
         e_diff   = a_exp - b_exp;
      end else begin
         al_big_s = op_r[15]; al_big_e = b_exp; al_big_m = b_mant;
         al_sml_s = acc[15];  al_sml_m = a_mant;
         e_diff   = b_exp - a_exp;
      end
      al_shift_m = (e_diff >= 5'(MW)) ? '0 : (al_sml_m >> e_diff);
   end

   // Signed-magnitude add
   logic [MW:0] add_sum;
   logic        add_sign;

   always_comb begin
      if (big_sign == sml_sign) begin
         add_sum  = {1'b0, big_mant} + {1'b0, sml_mant};
         add_sign = big_sign;
      end else if (big_mant >= sml_mant) begin
         add_sum  = {1'b0, big_mant} - {1'b0, sml_mant};
         add_sign = big_sign;
      end else begin
         add_sum  = {1'b0, sml_mant} - {1'b0, big_mant};
         add_sign = sml_sign;
      end
      if (add_sum == '0) add_sign = 1'b0;
   end

   // Normalize, flush/saturate, truncate guard bits
   logic [3:0]        lz;
   logic [MW-1:0]     norm_m;
   logic signed [6:0] norm_e;
   logic [15:0]       norm_res;

   always_comb begin
      lz = 4'd14;
      for (int i = 0; i < int'(MW); i++)
         if (sum_r[i]) lz = 4'(13 - i);
      if (sum_r[MW]) begin
         norm_m = sum_r[MW:1];
         norm_e = $signed({2'b00, sum_exp}) + 7'sd1;
      end else begin
         norm_m = sum_r[MW-1:0] << lz;
         norm_e = $signed({2'b00, sum_exp}) - $signed({3'b000, lz});
      end
      if (sum_r == '0 || norm_e <= 7'sd0)
         norm_res = 16'h0000;
      else if (norm_e >= 7'sd31)
         norm_res = {sum_sign, 15'h7BFF};
      else
         norm_res = {sum_sign, norm_e[4:0], norm_m[12:3]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         acc      <= 16'h0000;
         op_r     <= 16'h0000;
         last_r   <= 1'b0;
         count    <= '0;
         big_sign <= 1'b0;
         sml_sign <= 1'b0;
         big_exp  <= '0;
         big_mant <= '0;
         sml_mant <= '0;
         sum_r    <= '0;
         sum_sign <= 1'b0;
         sum_exp  <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_r   <= in_data;
               last_r <= in_last;
               if (count != '1) count <= count + CNT_W'(1);
               state  <= ALIGN;
            end
            ALIGN: begin
               big_sign <= al_big_s;
               big_exp  <= al_big_e;
               big_mant <= al_big_m;
               sml_sign <= al_sml_s;
               sml_mant <= al_shift_m;
               state    <= ADD;
            end
            ADD: begin
               sum_r    <= add_sum;
               sum_sign <= add_sign;
               sum_exp  <= big_exp;
               state    <= NORM;
            end
            NORM: begin
               acc   <= norm_res;
               state <= last_r ? OUT : IDLE;
            end
            OUT: if (out_ready) begin
               acc   <= 16'h0000;
               count <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_acc.sv
// Directed bench for fp16_acc: hand-computed group sums, timing, backpressure, reset.
module tb_fp16_acc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic [7:0]  out_count;

   int n_cmp = 0;
   int n_bad = 0;

   fp16_acc #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
   );

   always #5 clk = ~clk;

   // Present one element and return #1 after the accepting edge
   task automatic send(input logic [15:0] d, input logic l);
      int tries;
      tries = 0;
      @(negedge clk);
      while (!in_ready && tries < 40) begin
         @(negedge clk);
         tries++;
      end
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid, capture, then pop the result
   task automatic get_result(output logic [15:0] s, output logic [7:0] c,
                             output int lat, output bit ok);
      ok = 1'b0; lat = 0; s = 'x; c = 'x;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1; lat = i; s = out_sum; c = out_count;
            break;
         end
      end
      if (ok) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'h0000 || out_count !== 8'd0) begin
         n_bad++;
         $display("FAIL reset: valid=%b ready=%b sum=%h cnt=%0d required 0 1 0000 0",
                  out_valid, in_ready, out_sum, out_count);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_single;
      logic [15:0] s; logic [7:0] c; int lat; bit ok;
      send(16'h3C00, 1'b1);
      get_result(s, c, lat, ok);
      n_cmp++;
      // valid seen at the 4th negedge after accept = after the 3rd following edge
      if (!ok || s !== 16'h3C00 || c !== 8'd1 || lat != 4) begin
         n_bad++;
         $display("FAIL single: ok=%b sum=%h cnt=%0d lat=%0d required 3c00 1 4", ok, s, c, lat);
      end
   endtask

   task automatic test_group;
      logic [15:0] s; logic [7:0] c; int lat; bit ok;
      logic [15:0] vec [3] = '{16'h3C00, 16'h4000, 16'h3800};
      for (int k = 0; k < 3; k++) begin
         send(vec[k], k == 2);
         for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0) begin
               n_bad++;
               $display("FAIL group_busy: elem %0d cycle %0d in_ready=%b required 0", k, j, in_ready);
            end
         end
         if (k < 2) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1) begin
               n_bad++;
               $display("FAIL group_ready: elem %0d in_ready=%b required 1", k, in_ready);
            end
         end
      end
      get_result(s, c, lat, ok);
      n_cmp++;
      if (!ok || s !== 16'h4300 || c !== 8'd3) begin
         n_bad++;
         $display("FAIL group_sum: ok=%b sum=%h cnt=%0d required 4300 3", ok, s, c);
      end
   endtask

   task automatic test_pairs;
      logic [15:0] s; logic [7:0] c; int lat; bit ok;
      logic [15:0] a   [6] = '{16'h3C00, 16'h0200, 16'h7BFF, 16'hFBFF, 16'h6400, 16'h3C00};
      logic [15:0] b   [6] = '{16'hBC00, 16'h3C00, 16'h7BFF, 16'hFBFF, 16'h3400, 16'h3555};
      logic [15:0] exp [6] = '{16'h0000, 16'h3C00, 16'h7BFF, 16'hFBFF, 16'h6400, 16'h3D55};
      for (int k = 0; k < 6; k++) begin
         send(a[k], 1'b0);
         send(b[k], 1'b1);
         get_result(s, c, lat, ok);
         n_cmp++;
         if (!ok || s !== exp[k] || c !== 8'd2) begin
            n_bad++;
            $display("FAIL pair_%0d: %h+%h ok=%b sum=%h cnt=%0d required %h 2",
                     k, a[k], b[k], ok, s, c, exp[k]);
         end
      end
      send(16'h7C00, 1'b1);
      get_result(s, c, lat, ok);
      n_cmp++;
      if (!ok || s !== 16'h7BFF || c !== 8'd1) begin
         n_bad++;
         $display("FAIL inf_in: ok=%b sum=%h cnt=%0d required 7bff 1", ok, s, c);
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] s; logic [7:0] c; int lat; bit ok;
      bit seen;
      send(16'h3C00, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL bp_valid: out_valid never rose, required 1");
      end
      in_data = 16'h4000; in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'h3C00 || out_count !== 8'd1) begin
            n_bad++;
            $display("FAIL bp_hold: cyc %0d ready=%b valid=%b sum=%h cnt=%0d required 0 1 3c00 1",
                     i, in_ready, out_valid, out_sum, out_count);
         end
      end
      in_valid = 1'b0;
      get_result(s, c, lat, ok);
      send(16'h4000, 1'b1);
      get_result(s, c, lat, ok);
      n_cmp++;
      if (!ok || s !== 16'h4000 || c !== 8'd1) begin
         n_bad++;
         $display("FAIL bp_next: ok=%b sum=%h cnt=%0d required 4000 1", ok, s, c);
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] s; logic [7:0] c; int lat; bit ok;
      send(16'h3C00, 1'b0);
      send(16'h4000, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'h0000 || out_count !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_mid: valid=%b ready=%b sum=%h cnt=%0d required 0 1 0000 0",
                  out_valid, in_ready, out_sum, out_count);
      end
      @(negedge clk) rst_n = 1'b1;
      send(16'h3800, 1'b1);
      get_result(s, c, lat, ok);
      n_cmp++;
      if (!ok || s !== 16'h3800 || c !== 8'd1) begin
         n_bad++;
         $display("FAIL reset_after: ok=%b sum=%h cnt=%0d required 3800 1", ok, s, c);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_group();
      test_pairs();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
